// File: rtl/conv_pkg.sv
// conv_pkg: shared types and defaults for the convolution frame controller.
//   conv_ctrl_state_e : frame sequencer states
//   conv_tag_t        : per-pixel tag carried alongside the core pipeline
//   DefWordSize/DefCols : default pixel width and line length
package conv_pkg;

  localparam int unsigned DefWordSize = 8;
  localparam int unsigned DefCols     = 540;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StFlush,
    StDone
  } conv_ctrl_state_e;

  typedef struct packed {
    logic v;     // window centre is an interior result
    logic last;  // final pixel of the frame
  } conv_tag_t;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: valid/ready pixel stream into the frame controller.
//   in_pixel : source pixel, raster order
//   in_valid : source pixel valid
//   in_ready : controller accepts the pixel this cycle
// Modports: master = pixel source, slave = controller.
interface conv_frame_ctrl_if #(
  parameter int unsigned WORD_SIZE = conv_pkg::DefWordSize
) ();

  logic [WORD_SIZE-1:0] in_pixel;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_pixel, output in_valid, input in_ready);
  modport slave  (input in_pixel, input in_valid, output in_ready);

endinterface

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: tag shift register running in lock-step with the core pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : advance one stage (core clock-enable)
//   clr_i    : synchronous clear of every stage
//   tag_i    : tag entering stage 0
//   tag_o    : tag of the final stage
// The final stage is one-shot: when the pipe does not advance it drops its tag, so a
// result is presented for exactly one cycle even if the core is stalled afterwards.
module conv_tag_pipe
  import conv_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      clr_i,
  input  conv_tag_t tag_i,
  output conv_tag_t tag_o
);

  conv_tag_t stage_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end else begin
      stage_q[Depth-1] <= '0;
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer in front of the streaming 3x3 convolution core.
// Accepts ROWS x COLS pixels, clears the core at frame start, flushes it at frame end
// and tags each core output with valid/row/column so only interior results are seen.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : begin a frame (IDLE only)
//   abort_i         : terminate the current frame (CLEAR/RUN/FLUSH)
//   src             : pixel stream, slave side (in_pixel/in_valid/in_ready)
//   core_pixel_o    : pixel to the core
//   core_en_o       : core clock-enable
//   core_clr_o      : one-cycle clear to the core
//   out_valid_o     : core output holds a valid interior result
//   out_row_o/col_o : window centre coordinates of that result
//   out_last_o      : final result of the frame
//   busy_o, done_o  : not idle / frame completed pulse
// Optional build macro CONV_FRAME_CTRL_STATS_EN adds:
//   stat_frames_o   : completed frames, saturating
//   stat_stalls_o   : RUN cycles without input, saturating, cleared per frame
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DefWordSize,
  parameter int unsigned ROWS      = 540,
  parameter int unsigned COLS      = DefCols,
  parameter int unsigned CORE_LAT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  conv_frame_ctrl_if.slave         src,
  output logic [WORD_SIZE-1:0]     core_pixel_o,
  output logic                     core_en_o,
  output logic                     core_clr_o,
  output logic                     out_valid_o,
  output logic [$clog2(ROWS)-1:0]  out_row_o,
  output logic [$clog2(COLS)-1:0]  out_col_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef CONV_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]              stat_frames_o,
  output logic [31:0]              stat_stalls_o
`endif
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned LatW = $clog2(CORE_LAT + 1);

  conv_ctrl_state_e state_q, state_d;
  logic [RowW-1:0]  row_q, row_d, out_row_q, out_row_d;
  logic [ColW-1:0]  col_q, col_d, out_col_q, out_col_d;
  logic [LatW-1:0]  flush_q, flush_d;

  logic      accept;
  logic      in_last;
  logic      abort_hit;
  conv_tag_t tag_in;
  conv_tag_t tag_out;

  assign in_last   = (row_q == RowW'(ROWS - 1)) && (col_q == ColW'(COLS - 1));
  assign abort_hit = abort_i && (state_q inside {StClear, StRun, StFlush});

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    flush_d      = flush_q;
    src.in_ready = 1'b0;
    core_en_o    = 1'b0;
    core_pixel_o = '0;
    core_clr_o   = 1'b0;
    accept       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StClear;
      end
      StClear: begin
        core_clr_o = 1'b1;
        row_d      = '0;
        col_d      = '0;
        flush_d    = '0;
        state_d    = StRun;
      end
      StRun: begin
        src.in_ready = 1'b1;
        core_en_o    = src.in_valid;
        core_pixel_o = src.in_pixel;
        accept       = src.in_valid;
        if (accept) begin
          if (col_q == ColW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          if (in_last) state_d = StFlush;
        end
      end
      StFlush: begin
        // Zero pixels push the last real samples through the core.
        core_en_o = 1'b1;
        flush_d   = flush_q + LatW'(1);
        if (flush_q == LatW'(CORE_LAT - 1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      flush_q <= flush_d;
    end
  end

  // Interior means a full 3x3 window: the pixel completes a window centred one up-left.
  assign tag_in.v    = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
  assign tag_in.last = accept && in_last;

  conv_tag_pipe #(
    .Depth (CORE_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .en_i  (core_en_o),
    .clr_i (core_clr_o || abort_hit),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // The coordinate registers always hold the coordinate of the result being presented
  // (or the next one), so they are loaded with the first centre at frame start.
  always_comb begin
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (state_q == StClear) begin
      out_row_d = RowW'(1);
      out_col_d = ColW'(1);
    end else if (tag_out.v) begin
      if (out_col_q == ColW'(COLS - 2)) begin
        out_col_d = ColW'(1);
        out_row_d = out_row_q + RowW'(1);
      end else begin
        out_col_d = out_col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end

  assign out_valid_o = tag_out.v;
  assign out_last_o  = tag_out.last;
  assign out_row_o   = out_row_q;
  assign out_col_o   = out_col_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);

`ifdef CONV_FRAME_CTRL_STATS_EN
  logic [15:0] stat_frames_q;
  logic [31:0] stat_stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (state_q == StDone && stat_frames_q != '1) stat_frames_q <= stat_frames_q + 16'd1;
      if (state_q == StClear) begin
        stat_stalls_q <= '0;
      end else if (state_q == StRun && !src.in_valid && stat_stalls_q != '1) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_frames_o = stat_frames_q;
  assign stat_stalls_o = stat_stalls_q;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: directed bench for conv_frame_ctrl with ROWS=4, COLS=5, CORE_LAT=4.
// A negedge monitor models expected tags from the accepted pixel stream and checks
// every result; the main process sequences frames and checks per-frame totals.
module tb_conv_frame_ctrl;

  localparam int unsigned Rows    = 4;
  localparam int unsigned Cols    = 5;
  localparam int unsigned CoreLat = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic [7:0] core_pixel_o;
  logic       core_en_o;
  logic       core_clr_o;
  logic       out_valid_o;
  logic [1:0] out_row_o;
  logic [2:0] out_col_o;
  logic       out_last_o;
  logic       busy_o;
  logic       done_o;
`ifdef CONV_FRAME_CTRL_STATS_EN
  logic [15:0] stat_frames_o;
  logic [31:0] stat_stalls_o;
`endif

  conv_frame_ctrl_if #(.WORD_SIZE(8)) bus ();

  conv_frame_ctrl #(
    .WORD_SIZE (8),
    .ROWS      (Rows),
    .COLS      (Cols),
    .CORE_LAT  (CoreLat)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .src          (bus),
    .core_pixel_o (core_pixel_o),
    .core_en_o    (core_en_o),
    .core_clr_o   (core_clr_o),
    .out_valid_o  (out_valid_o),
    .out_row_o    (out_row_o),
    .out_col_o    (out_col_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef CONV_FRAME_CTRL_STATS_EN
    ,
    .stat_frames_o (stat_frames_o),
    .stat_stalls_o (stat_stalls_o)
`endif
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int en;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0, en_cnt = 0, start_cyc = 0, last_acc_cyc = 0;
  int   r_cnt = 0, c_cnt = 0;
  int   ov_cnt = 0, last_cnt = 0, acc_cnt = 0, flush_cnt = 0, done_cnt = 0;
  bit   last_seen = 0;

  // Reference model: tracks raster position of accepted pixels and predicts results.
  always @(negedge clk) begin
    if (!rst) begin
      if (start_i && !busy_o) start_cyc = cyc;
      if (core_clr_o) begin
        check_eq("clr_lat", cyc - start_cyc, 1);
        r_cnt = 0; c_cnt = 0; exp_q.delete();
        ov_cnt = 0; last_cnt = 0; acc_cnt = 0; flush_cnt = 0; last_seen = 0;
      end
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_ov", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("ov_row", out_row_o, mon_e.row);
          check_eq("ov_col", out_col_o, mon_e.col);
          check_eq("ov_last", out_last_o, mon_e.last);
          check_eq("ov_lat", en_cnt, mon_e.en);
        end
        ov_cnt++;
        if (out_last_o) begin
          last_cnt++;
          last_seen = 1;
        end
      end
      check_eq("last_gated", out_last_o && !out_valid_o, 0);
      if (abort_i && busy_o) exp_q.delete();
      if (bus.in_valid && bus.in_ready) begin
        check_eq("acc_en", core_en_o, 1);
        check_eq("acc_pix", core_pixel_o, bus.in_pixel);
        if (r_cnt >= 2 && c_cnt >= 2) begin
          mon_e.en   = en_cnt + CoreLat;
          mon_e.row  = r_cnt - 1;
          mon_e.col  = c_cnt - 1;
          mon_e.last = (r_cnt == Rows - 1) && (c_cnt == Cols - 1);
          exp_q.push_back(mon_e);
        end
        if (r_cnt == Rows - 1 && c_cnt == Cols - 1) last_acc_cyc = cyc;
        acc_cnt++;
        if (c_cnt == Cols - 1) begin
          c_cnt = 0;
          r_cnt++;
        end else begin
          c_cnt++;
        end
      end
      if (bus.in_ready && !bus.in_valid) check_eq("gap_en", core_en_o, 0);
      if (busy_o && !bus.in_ready && !core_clr_o && !done_o) begin
        flush_cnt++;
        check_eq("flush_en", core_en_o, 1);
        check_eq("flush_pix", core_pixel_o, 0);
      end
      if (done_o) begin
        done_cnt++;
        check_eq("done_lat", cyc - last_acc_cyc, CoreLat + 1);
        check_eq("last_before_done", last_seen, 1);
      end
      if (core_en_o) en_cnt++;
      cyc++;
    end
  end

  task automatic start_frame();
    int n = 0;
    start_i = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!busy_o && n < 4);
    start_i = 1'b0;
    check_eq("start_busy", busy_o, 1);
  endtask

  task automatic send_pixel(input logic [7:0] px, input int gaps);
    int n = 0;
    bit ok = 0;
    if (gaps > 0) begin
      bus.in_valid = 1'b0;
      repeat (gaps) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = px;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) check_eq("accept_timeout", 0, 1);
  endtask

  // mode 0: continuous, 1: random gaps, 2: spurious starts in RUN/FLUSH, 3: 7 stalls
  task automatic feed_frame(input int mode, input int npix);
    int gaps;
    for (int i = 0; i < npix; i++) begin
      gaps = 0;
      if (mode == 1 && i > 0 && $urandom_range(0, 1) == 1) gaps = int'($urandom_range(1, 2));
      if (mode == 3 && i >= 3 && i <= 9) gaps = 1;
      if (mode == 2 && i == 8) start_i = 1'b1;
      send_pixel(8'((i * 7 + mode * 3 + 1) & 255), gaps);
      start_i = 1'b0;
    end
    if (npix == int'(Rows * Cols)) begin
      bus.in_valid = 1'b0;
      if (mode == 2) begin
        start_i = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
        end
        start_i = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_frame(input string name, input int mode);
    int d0 = done_cnt;
    start_frame();
    feed_frame(mode, Rows * Cols);
    wait_done(d0);
    check_eq({name, "_ov_cnt"}, ov_cnt, (Rows - 2) * (Cols - 2));
    check_eq({name, "_last_cnt"}, last_cnt, 1);
    check_eq({name, "_acc_cnt"}, acc_cnt, Rows * Cols);
    check_eq({name, "_flush_cnt"}, flush_cnt, CoreLat);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_busy"}, busy_o, 0);
    check_eq({name, "_done"}, done_o, 0);
    check_eq({name, "_ready"}, bus.in_ready, 0);
    check_eq({name, "_en"}, core_en_o, 0);
    check_eq({name, "_clr"}, core_clr_o, 0);
    check_eq({name, "_pix"}, core_pixel_o, 0);
    check_eq({name, "_ov"}, out_valid_o, 0);
    check_eq({name, "_last"}, out_last_o, 0);
    check_eq({name, "_row"}, out_row_o, 0);
    check_eq({name, "_col"}, out_col_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, required to finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst          = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    bus.in_valid = 1'b1;  // ignored while idle
    bus.in_pixel = 8'hA5;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
`ifdef CONV_FRAME_CTRL_STATS_EN
    check_eq("reset_stat_frames", stat_frames_o, 0);
    check_eq("reset_stat_stalls", stat_stalls_o, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_en_with_valid", core_en_o, 0);
    bus.in_valid = 1'b0;

    run_frame("contig", 0);
    run_frame("gaps", 1);
    run_frame("spurious_start", 2);
    // Called while DONE is showing: start is held into the following IDLE cycle.
    run_frame("back_to_back", 0);
    repeat (3) @(posedge clk);
    #1;

    // Abort after 12 accepted pixels.
    d0 = done_cnt;
    start_frame();
    feed_frame(0, 12);
    bus.in_valid = 1'b0;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check_eq("abort_busy", busy_o, 0);
    check_eq("abort_en", core_en_o, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_acc_cnt", acc_cnt, 12);
    check_eq("abort_ov_cnt", ov_cnt, 0);
    check_eq("abort_no_done", done_cnt - d0, 0);
    run_frame("after_abort", 0);

    // Asynchronous reset in the middle of FLUSH.
    start_frame();
    feed_frame(0, Rows * Cols);
    #2;
    check_eq("pre_rst_busy", busy_o, 1);
    check_eq("pre_rst_ready", bus.in_ready, 0);
    check_eq("pre_rst_en", core_en_o, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_busy", busy_o, 0);

    run_frame("stats_a", 0);
    run_frame("stats_b", 1);
    run_frame("stats_c", 3);
`ifdef CONV_FRAME_CTRL_STATS_EN
    @(posedge clk); #1;
    check_eq("stat_frames", stat_frames_o, 3);
    check_eq("stat_stalls", stat_stalls_o, 7);
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer in front of the streaming 3x3 convolution core.
- Accepts one frame of ROWS x COLS pixels over a valid/ready stream and drives the core's pixel input and clock-enable.
- Clears the core at frame start and flushes its pipeline at frame end.
- Tags each core output with valid, row and column, so downstream logic sees only interior (fully-windowed) results.

Parameters:
- WORD_SIZE, 8, pixel width.
- ROWS, 540, frame height in pixels (>=3).
- COLS, 540, frame width in pixels; must equal the core's ROW_SIZE (>=3).
- CORE_LAT, 4, number of enabled core cycles from pixel accept to corresponding core output register update (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  terminate the current frame; honoured in any non-IDLE state.
- in_pixel  in  WORD_SIZE  source pixel, raster order.
- in_valid  in  1  source pixel valid.
- in_ready  out  1  controller accepts the pixel this cycle.
- core_pixel  out  WORD_SIZE  pixel to the core.
- core_en  out  1  core clock-enable; the core advances only when high.
- core_clr  out  1  one-cycle synchronous clear to the core.
- out_valid  out  1  core output holds a valid interior result this cycle.
- out_row  out  $clog2(ROWS)  row of the window centre, range 1..ROWS-2.
- out_col  out  $clog2(COLS)  column of the window centre, range 1..COLS-2.
- out_last  out  1  with out_valid: final result of the frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset values: all outputs 0. State IDLE. Counters and tag pipe cleared. Reset is asynchronous and takes effect mid-frame identically.
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE:
  - in_ready=0, core_en=0.
  - start=1 -> CLEAR. Otherwise start is ignored.
- CLEAR (1 cycle):
  - core_clr=1.
  - Input row/col counters, output counters and tag pipe zeroed.
  - -> RUN.
- RUN:
  - in_ready=1.
  - core_en = in_valid (combinational). core_pixel = in_pixel (combinational). No added latency.
  - Accept = in_valid & in_ready.
  - On accept: col++; on col==COLS-1, col wraps to 0 and row++.
  - A stall (in_valid=0) freezes the core, tags and counters.
  - Accept at (ROWS-1, COLS-1) -> FLUSH.
- FLUSH:
  - in_ready=0, core_en=1, core_pixel=0 for exactly CORE_LAT cycles.
  - -> DONE.
- DONE (1 cycle): done=1, -> IDLE.
- abort in CLEAR/RUN/FLUSH:
  - Next state IDLE; core_en=0 from the following cycle.
  - Tag pipe cleared; no further out_valid; done not pulsed.
  - abort has priority over all transitions.
- Tagging:
  - Each accepted pixel at (r,c) carries tag v = (r>=2 && c>=2). out_last = that pixel is (ROWS-1, COLS-1).
  - Tags advance only on core_en.
  - With continuous input, pixel accepted in cycle t produces out_valid in cycle t+CORE_LAT, aligned with the core's output register. Under stalls, the same holds counted in enabled cycles.
  - out_valid, out_row, out_col and out_last are registered.
- Output coordinates:
  - Start at (1,1).
  - On each out_valid, out_col++. At COLS-2, out_col wraps to 1 and out_row++.
- Per-frame counts:
  - Exactly (ROWS-2)*(COLS-2) out_valid pulses.
  - out_last is asserted only on the final pulse, which always occurs before done.

Optional Feature:
- Macro: CONV_FRAME_CTRL_STATS_EN.
- When defined, two extra output ports:
  - stat_frames (16b): count of completed frames, saturating.
  - stat_stalls (32b): count of RUN cycles with in_valid=0, saturating, cleared in CLEAR.
- Both reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package conv_pkg:
  - state enum conv_ctrl_state_e.
  - tag struct conv_tag_t {v, last}.
  - Shared defaults for WORD_SIZE and COLS.
- One sub-module, conv_tag_pipe: depth-parameterised shift register with enable and synchronous clear, holding conv_tag_t.

Test Plan (ROWS=4, COLS=5, CORE_LAT=4 unless noted):
- Continuous frame, in_valid always 1:
  - core_clr pulse 1 cycle after start.
  - 20 accepts.
  - 6 out_valid with coordinates (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - out_last only on (2,3).
  - done 4 cycles after the last accept plus 1.
- Random in_valid gaps (~50%):
  - Identical out_valid sequence and coordinates.
  - core_en never high during gaps.
  - out_valid spacing tracks enabled cycles.
- start asserted during RUN and FLUSH: ignored, counts unchanged. start in the DONE-to-IDLE cycle begins a second clean frame.
- abort after 12 accepts:
  - busy falls next cycle; no further out_valid; done=0.
  - A following start yields a full correct frame.
- rst asserted asynchronously mid-FLUSH: all outputs 0 immediately without a clock edge; state IDLE.
- With CONV_FRAME_CTRL_STATS_EN: 3 frames with 7 stall cycles in the last frame -> stat_frames=3, stat_stalls=7.
